// File: rtl/fall_through_register_flushable_pkg.sv
// Width helpers for the flushable fall-through register.
package fall_through_register_flushable_pkg;

    // Bits needed to hold an occupancy count from 0 up to and including depth.
    function automatic int unsigned ftr_cnt_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Bits needed to address depth storage entries; at least one bit.
    function automatic int unsigned ftr_ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fall_through_register_flushable.sv
// Flushable zero-latency valid/ready stage. Payload falls straight through
// when storage is empty; ready_o is taken from registered occupancy only, so
// the downstream ready path is cut without adding forward latency.
module fall_through_register_flushable
    import fall_through_register_flushable_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  DEPTH      = 2,
    parameter bit           Bypass     = 1'b0,
    localparam int unsigned UsageW     = ftr_cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [UsageW-1:0]     usage_o
);

    localparam int unsigned       PtrW    = ftr_ptr_width(DEPTH);
    localparam logic [PtrW-1:0]   LastPtr = PtrW'(DEPTH - 1);
    localparam logic [UsageW-1:0] FullCnt = UsageW'(DEPTH);

    // Circular buffer state
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [UsageW-1:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Handshake decode
    logic                  empty;
    logic                  full;
    logic                  ft_valid;
    logic                  ft_ready;
    logic [DATA_WIDTH-1:0] ft_data;
    logic                  in_hs;
    logic                  out_hs;
    logic                  push;
    logic                  pop;

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Derive fall-through outputs and push/pop from registered state and inputs.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FullCnt);
        // Only registered occupancy feeds ready, never ready_i or flush_i.
        ft_ready = !full;
        ft_valid = (!empty || valid_i) && !flush_i;
        ft_data  = empty ? data_i : mem_q[rd_ptr_q];
        in_hs    = valid_i && ft_ready && !flush_i;
        out_hs   = ft_valid && ready_i;
        // An empty stage with a ready consumer passes the beat through unstored.
        push     = in_hs && !(empty && ready_i);
        pop      = out_hs && !empty;
    end

    // Next-state for pointers, count and storage; flush wins over everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + UsageW'(1);
            end else if (pop && !push) begin
                count_d = count_q - UsageW'(1);
            end
        end
    end

    // Control state registers; asynchronous reset empties the stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage registers; cleared on reset only to keep simulation X-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    if (Bypass) begin : g_bypass
        // Pure wires: storage above is left unconnected and trims away.
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;
    end else begin : g_stage
        assign valid_o = ft_valid;
        assign ready_o = ft_ready;
        assign data_o  = ft_data;
        assign usage_o = count_q;

`ifndef SYNTHESIS
        a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
            count_q <= FullCnt)
            else $error("occupancy above DEPTH");

        a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(push && full))
            else $error("push while full");

        a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(pop && empty))
            else $error("pop while empty");

        // A stored head shown without ready must not change under the consumer.
        a_head_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (ft_valid && !ready_i && !empty) |=> $stable(data_o))
            else $error("stored head changed while stalled");

        // Upstream should not offer a beat in the flush cycle; it gets dropped.
        a_valid_flush : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(valid_i && flush_i))
            else $warning("valid_i asserted during flush_i; beat discarded");
`endif
    end

endmodule
